// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
// Stall, flush and halt sequencer for the 5-stage MIPS pipeline. Resolves the
// hazards that EX-stage forwarding cannot: load-use and branch-operand hazards
// for branches compared in ID. It also sequences HALT by draining the pipeline
// and then raising a sticky halted flag.
//
// Ports:
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   i_rs_ID/i_rt_ID          source registers of the ID instruction
//   i_uses_rs_ID/_rt_ID      ID instruction actually reads rs/rt
//   i_branch_ID              ID instruction is a conditional branch
//   i_taken_ID               branch taken or jump in ID
//   i_halt_ID                ID instruction is HALT
//   i_rd_EX, i_RegWrite_EX,
//   i_MemRead_EX             destination/kind of the EX instruction
//   i_rd_M, i_MemRead_M      destination/kind of the MEM instruction
//   o_pc_write               PC update enable (combinational)
//   o_IF_ID_write            IF/ID enable (combinational)
//   o_ID_EX_bubble           zero ID/EX control fields (combinational)
//   o_IF_ID_flush            clear IF/ID on next edge (combinational)
//   o_halted                 pipeline drained after HALT, sticky (registered)
//   o_stall_cnt              saturating hazard-stall cycle count (registered)
module hazard_stall_unit #(
  parameter int unsigned NB_REG = 5,
  parameter int unsigned NB_CNT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NB_REG-1:0] i_rs_ID,
  input  logic [NB_REG-1:0] i_rt_ID,
  input  logic              i_uses_rs_ID,
  input  logic              i_uses_rt_ID,
  input  logic              i_branch_ID,
  input  logic              i_taken_ID,
  input  logic              i_halt_ID,
  input  logic [NB_REG-1:0] i_rd_EX,
  input  logic              i_RegWrite_EX,
  input  logic              i_MemRead_EX,
  input  logic [NB_REG-1:0] i_rd_M,
  input  logic              i_MemRead_M,
  output logic              o_pc_write,
  output logic              o_IF_ID_write,
  output logic              o_ID_EX_bubble,
  output logic              o_IF_ID_flush,
  output logic              o_halted,
  output logic [NB_CNT-1:0] o_stall_cnt
);

  localparam int unsigned NB_DRAIN = 2;
  localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(3);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NB_DRAIN-1:0] drain_q, drain_d;
  logic                halted_q, halted_d;
  logic [NB_CNT-1:0]   stall_cnt_q, stall_cnt_d;

  logic match_ex_c;
  logic match_m_c;
  logic load_use_c;
  logic branch_alu_c;
  logic branch_load_ex_c;
  logic branch_load_m_c;
  logic hazard_c;

  logic pc_write_c;
  logic if_id_write_c;
  logic id_ex_bubble_c;
  logic if_id_flush_c;

  // Producer/consumer register matching; $0 never creates a dependency.
  always_comb begin
    match_ex_c = (i_rd_EX != '0) &&
                 ((i_uses_rs_ID && (i_rd_EX == i_rs_ID)) ||
                  (i_uses_rt_ID && (i_rd_EX == i_rt_ID)));
    match_m_c  = (i_rd_M != '0) &&
                 ((i_uses_rs_ID && (i_rd_M == i_rs_ID)) ||
                  (i_uses_rt_ID && (i_rd_M == i_rt_ID)));
  end

  // Hazard classes. A branch after a load stalls as branch-load-EX, then the
  // load moves to MEM and the same branch re-stalls as branch-load-M.
  always_comb begin
    load_use_c       = i_MemRead_EX && match_ex_c;
    branch_alu_c     = i_branch_ID && i_RegWrite_EX && !i_MemRead_EX && match_ex_c;
    branch_load_ex_c = i_branch_ID && i_MemRead_EX && match_ex_c;
    branch_load_m_c  = i_branch_ID && i_MemRead_M && match_m_c;
    hazard_c         = load_use_c | branch_alu_c | branch_load_ex_c | branch_load_m_c;
  end

  // Next-state and pipeline control; outputs default to the frozen/bubble form.
  always_comb begin
    state_d        = state_q;
    drain_d        = drain_q;
    halted_d       = halted_q;
    stall_cnt_d    = stall_cnt_q;
    pc_write_c     = 1'b0;
    if_id_write_c  = 1'b0;
    id_ex_bubble_c = 1'b1;
    if_id_flush_c  = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (hazard_c) begin
          // Stall wins over HALT and over a taken branch; both retry next cycle.
          if (stall_cnt_q != {NB_CNT{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + NB_CNT'(1);
          end
        end else if (i_halt_ID) begin
          // HALT is swallowed as a bubble and the front end stays frozen.
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          pc_write_c     = 1'b1;
          if_id_write_c  = 1'b1;
          id_ex_bubble_c = 1'b0;
          if_id_flush_c  = i_taken_ID;
        end
      end
      ST_DRAIN: begin
        if (drain_q == NB_DRAIN'(1)) begin
          state_d  = ST_HALTED;
          drain_d  = '0;
          halted_d = 1'b1;
        end else begin
          drain_d = drain_q - NB_DRAIN'(1);
        end
      end
      ST_HALTED: begin
        halted_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        drain_d = '0;
      end
    endcase

    // Front end held frozen while reset is asserted.
    if (!i_rst_n) begin
      pc_write_c     = 1'b0;
      if_id_write_c  = 1'b0;
      id_ex_bubble_c = 1'b1;
      if_id_flush_c  = 1'b0;
    end
  end

  // State, drain counter, halted flag and stall counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_RUN;
      drain_q     <= '0;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      halted_q    <= halted_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_pc_write     = pc_write_c;
  assign o_IF_ID_write  = if_id_write_c;
  assign o_ID_EX_bubble = id_ex_bubble_c;
  assign o_IF_ID_flush  = if_id_flush_c;
  assign o_halted       = halted_q;
  assign o_stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs_id, rt_id, rd_ex, rd_m;
  logic        uses_rs, uses_rt, branch_id, taken_id, halt_id;
  logic        regwrite_ex, memread_ex, memread_m;
  logic        pc_write, if_id_write, id_ex_bubble, if_id_flush, halted;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_stall_unit #(.NB_REG(5), .NB_CNT(16)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_rs_ID       (rs_id),
    .i_rt_ID       (rt_id),
    .i_uses_rs_ID  (uses_rs),
    .i_uses_rt_ID  (uses_rt),
    .i_branch_ID   (branch_id),
    .i_taken_ID    (taken_id),
    .i_halt_ID     (halt_id),
    .i_rd_EX       (rd_ex),
    .i_RegWrite_EX (regwrite_ex),
    .i_MemRead_EX  (memread_ex),
    .i_rd_M        (rd_m),
    .i_MemRead_M   (memread_m),
    .o_pc_write    (pc_write),
    .o_IF_ID_write (if_id_write),
    .o_ID_EX_bubble(id_ex_bubble),
    .o_IF_ID_flush (if_id_flush),
    .o_halted      (halted),
    .o_stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are changed #1 after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs_id = '0; rt_id = '0; rd_ex = '0; rd_m = '0;
    uses_rs = 0; uses_rt = 0; branch_id = 0; taken_id = 0; halt_id = 0;
    regwrite_ex = 0; memread_ex = 0; memread_m = 0;
  endtask

  // Stalled form: {pc_write, if_id_write, bubble, flush} = 4'b0010.
  // Run form with flush f: {1,1,0,f}.
  task automatic test_reset();
    clear_inputs();
    taken_id = 1; memread_ex = 1; rd_ex = 5'd3; rs_id = 5'd3; uses_rs = 1;
    rst_n = 0;
    step(); step();
    #1;
    checks++;
    if ({pc_write, if_id_write, id_ex_bubble, if_id_flush} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=0010", {pc_write, if_id_write, id_ex_bubble, if_id_flush});
    end
    checks++;
    if (halted !== 1'b0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_regs got halted=%b cnt=%0d exp halted=0 cnt=0", halted, stall_cnt);
    end
    clear_inputs();
    rst_n = 1;
    #1;
    checks++;
    if ({pc_write, if_id_write, id_ex_bubble, if_id_flush} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_release got=%b exp=1100", {pc_write, if_id_write, id_ex_bubble, if_id_flush});
    end
  endtask

  task automatic test_no_false_stall();
    // Load to $0 feeding a $0 consumer.
    clear_inputs();
    memread_ex = 1; regwrite_ex = 1; rd_ex = 5'd0; rs_id = 5'd0; uses_rs = 1;
    #1;
    checks++;
    if ({pc_write, id_ex_bubble} !== 2'b10) begin
      errors++;
      $display("FAIL zero_reg got pc_write/bubble=%b exp=10", {pc_write, id_ex_bubble});
    end
    // Matching register number but the operand is not read.
    rd_ex = 5'd7; rs_id = 5'd7; uses_rs = 0;
    #1;
    checks++;
    if ({pc_write, id_ex_bubble} !== 2'b10) begin
      errors++;
      $display("FAIL unused_operand got pc_write/bubble=%b exp=10", {pc_write, id_ex_bubble});
    end
    // Load in MEM ahead of a non-branch consumer is forwarded, no stall.
    clear_inputs();
    memread_m = 1; rd_m = 5'd4; rt_id = 5'd4; uses_rt = 1;
    #1;
    checks++;
    if ({pc_write, id_ex_bubble} !== 2'b10) begin
      errors++;
      $display("FAIL load_in_mem_nonbranch got pc_write/bubble=%b exp=10", {pc_write, id_ex_bubble});
    end
    step();
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL no_stall_cnt got=%0d exp=0", stall_cnt);
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    memread_ex = 1; regwrite_ex = 1; rd_ex = 5'd3; rs_id = 5'd3; uses_rs = 1;
    #1;
    checks++;
    if ({pc_write, if_id_write, id_ex_bubble, if_id_flush} !== 4'b0010) begin
      errors++;
      $display("FAIL load_use_stall got=%b exp=0010", {pc_write, if_id_write, id_ex_bubble, if_id_flush});
    end
    step();
    // Load advanced to MEM, bubble in EX.
    memread_ex = 0; regwrite_ex = 0; rd_ex = '0; memread_m = 1; rd_m = 5'd3;
    #1;
    checks++;
    if ({pc_write, if_id_write, id_ex_bubble, if_id_flush} !== 4'b1100) begin
      errors++;
      $display("FAIL load_use_resume got=%b exp=1100", {pc_write, if_id_write, id_ex_bubble, if_id_flush});
    end
    checks++;
    if (stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL load_use_cnt got=%0d exp=1", stall_cnt);
    end
    step();
  endtask

  task automatic test_branch_alu();
    clear_inputs();
    branch_id = 1; taken_id = 1; regwrite_ex = 1; rd_ex = 5'd5; rt_id = 5'd5; uses_rt = 1;
    uses_rs = 1; rs_id = 5'd1;
    #1;
    checks++;
    if ({pc_write, if_id_write, id_ex_bubble, if_id_flush} !== 4'b0010) begin
      errors++;
      $display("FAIL branch_alu_stall got=%b exp=0010", {pc_write, if_id_write, id_ex_bubble, if_id_flush});
    end
    step();
    regwrite_ex = 0; rd_ex = '0; rd_m = 5'd5;
    #1;
    checks++;
    if ({pc_write, if_id_write, id_ex_bubble, if_id_flush} !== 4'b1101) begin
      errors++;
      $display("FAIL branch_alu_taken got=%b exp=1101", {pc_write, if_id_write, id_ex_bubble, if_id_flush});
    end
    step();
    checks++;
    if (stall_cnt !== 16'd2) begin
      errors++;
      $display("FAIL branch_alu_cnt got=%0d exp=2", stall_cnt);
    end
    // Taken, no hazard, then not taken: flush lasts one cycle.
    clear_inputs();
    #1;
    checks++;
    if (if_id_flush !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear got=%b exp=0", if_id_flush);
    end
  endtask

  task automatic test_branch_load();
    clear_inputs();
    branch_id = 1; taken_id = 1; memread_ex = 1; regwrite_ex = 1; rd_ex = 5'd5; rs_id = 5'd5; uses_rs = 1;
    #1;
    checks++;
    if ({pc_write, if_id_write, id_ex_bubble, if_id_flush} !== 4'b0010) begin
      errors++;
      $display("FAIL branch_load_ex got=%b exp=0010", {pc_write, if_id_write, id_ex_bubble, if_id_flush});
    end
    step();
    memread_ex = 0; regwrite_ex = 0; rd_ex = '0; memread_m = 1; rd_m = 5'd5;
    #1;
    checks++;
    if ({pc_write, if_id_write, id_ex_bubble, if_id_flush} !== 4'b0010) begin
      errors++;
      $display("FAIL branch_load_m got=%b exp=0010", {pc_write, if_id_write, id_ex_bubble, if_id_flush});
    end
    step();
    memread_m = 0; rd_m = '0;
    #1;
    checks++;
    if ({pc_write, if_id_write, id_ex_bubble, if_id_flush} !== 4'b1101) begin
      errors++;
      $display("FAIL branch_load_resume got=%b exp=1101", {pc_write, if_id_write, id_ex_bubble, if_id_flush});
    end
    checks++;
    if (stall_cnt !== 16'd4) begin
      errors++;
      $display("FAIL branch_load_cnt got=%0d exp=4", stall_cnt);
    end
    step();
  endtask

  task automatic test_halt();
    // HALT with a coincident load-use hazard: the stall is taken first.
    clear_inputs();
    halt_id = 1; memread_ex = 1; rd_ex = 5'd2; rt_id = 5'd2; uses_rt = 1;
    step();
    memread_ex = 0; rd_ex = '0;
    #1;
    checks++;
    if ({pc_write, if_id_write, id_ex_bubble, if_id_flush} !== 4'b0010) begin
      errors++;
      $display("FAIL halt_accept got=%b exp=0010", {pc_write, if_id_write, id_ex_bubble, if_id_flush});
    end
    checks++;
    if (stall_cnt !== 16'd5) begin
      errors++;
      $display("FAIL halt_hazard_cnt got=%0d exp=5", stall_cnt);
    end
    step(); // accept edge
    // In DRAIN, hazards and taken branches must neither count nor unfreeze.
    halt_id = 0; taken_id = 1; memread_ex = 1; rd_ex = 5'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({pc_write, if_id_write, id_ex_bubble, if_id_flush, halted} !== 5'b00100) begin
        errors++;
        $display("FAIL drain_cycle%0d got=%b exp=00100", i, {pc_write, if_id_write, id_ex_bubble, if_id_flush, halted});
      end
      step();
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL halted_set got=%b exp=1", halted);
    end
    clear_inputs();
    step(); step();
    checks++;
    if ({pc_write, id_ex_bubble, halted} !== 3'b011 || stall_cnt !== 16'd5) begin
      errors++;
      $display("FAIL halted_hold got pc/bub/halt=%b cnt=%0d exp=011 cnt=5", {pc_write, id_ex_bubble, halted}, stall_cnt);
    end
  endtask

  task automatic test_reset_in_drain();
    rst_n = 0; step(); rst_n = 1;
    clear_inputs();
    halt_id = 1;
    step(); // accept
    halt_id = 0;
    step(); // one DRAIN cycle
    rst_n = 0;
    #1;
    checks++;
    if ({pc_write, if_id_write, id_ex_bubble, if_id_flush} !== 4'b0010) begin
      errors++;
      $display("FAIL drain_reset_ctrl got=%b exp=0010", {pc_write, if_id_write, id_ex_bubble, if_id_flush});
    end
    step();
    rst_n = 1;
    #1;
    checks++;
    if ({pc_write, if_id_write, id_ex_bubble, halted} !== 4'b1100) begin
      errors++;
      $display("FAIL drain_reset_run got=%b exp=1100", {pc_write, if_id_write, id_ex_bubble, halted});
    end
    step(); step(); step(); step();
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL drain_reset_nohalt got=%b exp=0", halted);
    end
  endtask

  task automatic test_saturation();
    rst_n = 0; step(); rst_n = 1;
    clear_inputs();
    memread_ex = 1; rd_ex = 5'd9; rs_id = 5'd9; uses_rs = 1;
    repeat (65534) step();
    checks++;
    if (stall_cnt !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_near got=%h exp=fffe", stall_cnt);
    end
    step();
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_reach got=%h exp=ffff", stall_cnt);
    end
    repeat (6) step();
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold got=%h exp=ffff", stall_cnt);
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    test_reset();
    test_no_false_stall();
    test_load_use();
    test_branch_alu();
    test_branch_load();
    test_halt();
    test_reset_in_drain();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
